// File: rtl/wb_unit_mc.sv
// Writeback unit: merges the pipeline writeback slot with a queued
// long-latency result stream onto a single registered register-file port.
module wb_unit_mc #(
  parameter int XLEN         = 32,
  parameter int LLQ_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_valid,
  input  logic            pipe_regwrite,
  input  logic [4:0]      pipe_rd,
  input  logic [1:0]      pipe_result_src,
  input  logic [XLEN-1:0] pipe_alu_result,
  input  logic [XLEN-1:0] pipe_load_data,
  input  logic [XLEN-1:0] pipe_pc_plus4,
  input  logic [XLEN-1:0] pipe_imm,
  input  logic [2:0]      pipe_funct3,
  input  logic [1:0]      pipe_addr_lo,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [4:0]      ll_rd,
  input  logic [XLEN-1:0] ll_data,
  output logic            pipe_stall,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = $clog2(LLQ_DEPTH);
  localparam int CW = $clog2(LLQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      q_rd   [LLQ_DEPTH];
  logic [XLEN-1:0] q_data [LLQ_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;

  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] pipe_val;
  logic            pipe_wr;
  logic            push;
  logic            pop;

  assign ld_b = pipe_load_data[8*pipe_addr_lo +: 8];
  assign ld_h = pipe_addr_lo[1] ? pipe_load_data[31:16]
                                : pipe_load_data[15:0];

  always_comb begin
    ld_val = pipe_load_data;
    unique case (pipe_funct3)
      3'b000:  ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_b};
      3'b001:  ld_val = {{(XLEN-16){ld_h[15]}}, ld_h};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_h};
      default: ld_val = pipe_load_data;
    endcase
  end

  always_comb begin
    pipe_val = pipe_alu_result;
    unique case (pipe_result_src)
      2'd0: pipe_val = pipe_alu_result;
      2'd1: pipe_val = ld_val;
      2'd2: pipe_val = pipe_pc_plus4;
      2'd3: pipe_val = pipe_imm;
    endcase
  end

  // Stall comes only from the registered starvation counter.
  assign pipe_stall = (starve == SW'(STARVE_LIMIT));
  assign ll_ready   = (count != CW'(LLQ_DEPTH));

  assign pipe_wr = pipe_valid & pipe_regwrite
                 & (pipe_rd != 5'd0) & ~pipe_stall;
  assign push    = ll_valid & ll_ready;
  assign pop     = (count != '0) & ~pipe_wr;

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr]   <= ll_rd;
      q_data[wptr] <= ll_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      starve   <= '0;
    end else begin
      rf_we <= pipe_wr | (pop & (q_rd[rptr] != 5'd0));
      if (pipe_wr) begin
        rf_rd    <= pipe_rd;
        rf_wdata <= pipe_val;
      end else if (pop) begin
        rf_rd    <= q_rd[rptr];
        rf_wdata <= q_data[rptr];
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop || count == '0) starve <= '0;
      else                    starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unit_mc.sv
// Directed bench for wb_unit_mc: pipeline writes, load alignment,
// long-latency queue drain, full queue, starvation stall, reset.
module tb_wb_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid, pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [1:0]  pipe_result_src;
  logic [31:0] pipe_alu_result, pipe_load_data;
  logic [31:0] pipe_pc_plus4, pipe_imm;
  logic [2:0]  pipe_funct3;
  logic [1:0]  pipe_addr_lo;
  logic        ll_valid, ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        pipe_stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  wb_unit_mc #(.XLEN(32), .LLQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_regwrite(pipe_regwrite),
    .pipe_rd(pipe_rd), .pipe_result_src(pipe_result_src),
    .pipe_alu_result(pipe_alu_result),
    .pipe_load_data(pipe_load_data),
    .pipe_pc_plus4(pipe_pc_plus4), .pipe_imm(pipe_imm),
    .pipe_funct3(pipe_funct3), .pipe_addr_lo(pipe_addr_lo),
    .ll_valid(ll_valid), .ll_ready(ll_ready),
    .ll_rd(ll_rd), .ll_data(ll_data),
    .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd,
                        input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    chk({tag, "_rd"}, {27'd0, rf_rd}, {27'd0, rd});
    chk({tag, "_wd"}, rf_wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    pipe_valid = 0; pipe_regwrite = 0; pipe_rd = 0;
    pipe_result_src = 0; pipe_alu_result = 0; pipe_load_data = 0;
    pipe_pc_plus4 = 0; pipe_imm = 0; pipe_funct3 = 0;
    pipe_addr_lo = 0; ll_valid = 0; ll_rd = 0; ll_data = 0;
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_ready", {31'd0, ll_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // ALU write
    pipe_valid = 1; pipe_regwrite = 1; pipe_rd = 5;
    pipe_result_src = 0; pipe_alu_result = 32'h1234;
    tick();
    chk_wr("alu", 5'd5, 32'h0000_1234);

    // Load alignment
    pipe_rd = 6; pipe_result_src = 1; pipe_load_data = 32'h80FF_7F01;
    pipe_funct3 = 3'b000; pipe_addr_lo = 2'd3;
    tick();
    chk_wr("lb3", 5'd6, 32'hFFFF_FF80);
    pipe_funct3 = 3'b101; pipe_addr_lo = 2'd2;
    tick();
    chk("lhu2", rf_wdata, 32'h0000_80FF);
    pipe_funct3 = 3'b001; pipe_addr_lo = 2'd0;
    tick();
    chk("lh0", rf_wdata, 32'h0000_7F01);
    pipe_funct3 = 3'b100; pipe_addr_lo = 2'd1;
    tick();
    chk("lbu1", rf_wdata, 32'h0000_007F);
    pipe_funct3 = 3'b010; pipe_addr_lo = 2'd0;
    tick();
    chk("lw", rf_wdata, 32'h80FF_7F01);

    // PC+4 and immediate
    pipe_result_src = 2; pipe_pc_plus4 = 32'h0000_0104;
    tick();
    chk("pc4", rf_wdata, 32'h0000_0104);
    pipe_result_src = 3; pipe_imm = 32'hDEAD_0000;
    tick();
    chk("imm", rf_wdata, 32'hDEAD_0000);

    // Non-writing slots
    pipe_rd = 0;
    tick();
    chk("rd0_we", {31'd0, rf_we}, 32'd0);
    pipe_rd = 5; pipe_regwrite = 0;
    tick();
    chk("nowr_we", {31'd0, rf_we}, 32'd0);
    pipe_valid = 0; pipe_regwrite = 1;
    tick();
    chk("idle_we", {31'd0, rf_we}, 32'd0);

    // LL drain
    ll_valid = 1; ll_rd = 7; ll_data = 32'hAB;
    tick();
    ll_valid = 0;
    chk("ll_push_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk_wr("ll_drain", 5'd7, 32'h0000_00AB);
    ll_valid = 1; ll_rd = 0; ll_data = 32'h55;
    tick();
    ll_valid = 0;
    tick();
    chk("ll_rd0_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("ll_rd0_we2", {31'd0, rf_we}, 32'd0);
    chk("ll_empty_rdy", {31'd0, ll_ready}, 32'd1);

    // Full queue and starvation with pipe writing every cycle
    pipe_valid = 1; pipe_regwrite = 1; pipe_rd = 1;
    pipe_result_src = 0; pipe_alu_result = 32'h777;
    for (int i = 0; i < 4; i++) begin
      ll_valid = 1; ll_rd = 5'(10 + i); ll_data = 32'h100 + i;
      tick();
    end
    chk("full_rdy", {31'd0, ll_ready}, 32'd0);
    chk_wr("full_pipe", 5'd1, 32'h777);
    ll_rd = 14; ll_data = 32'h104;
    repeat (4) tick();
    chk("pre_stall", {31'd0, pipe_stall}, 32'd0);
    chk("held_rdy", {31'd0, ll_ready}, 32'd0);
    tick();
    chk("stall", {31'd0, pipe_stall}, 32'd1);
    tick();
    chk("stall_once", {31'd0, pipe_stall}, 32'd0);
    chk_wr("starve_head", 5'd10, 32'h100);
    chk("pop_rdy", {31'd0, ll_ready}, 32'd1);
    tick();
    ll_valid = 0; pipe_valid = 0;
    chk_wr("after_stall", 5'd1, 32'h777);
    chk("refill_rdy", {31'd0, ll_ready}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_wr($sformatf("order%0d", i), 5'(10 + i), 32'h100 + i);
    end
    tick();
    chk("drained_we", {31'd0, rf_we}, 32'd0);

    // Reset with three queued entries
    pipe_valid = 1; pipe_rd = 1;
    for (int i = 0; i < 3; i++) begin
      ll_valid = 1; ll_rd = 5'(20 + i); ll_data = 32'h200 + i;
      tick();
    end
    ll_valid = 0; pipe_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_we", {31'd0, rf_we}, 32'd0);
    chk("mrst_rdy", {31'd0, ll_ready}, 32'd1);
    chk("mrst_stall", {31'd0, pipe_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stale%0d", i), {31'd0, rf_we}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_unit_mc.md
WB_UNIT_MC -- requirements
Module: wb_unit_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter LLQ_DEPTH, default 4, long-latency result queue entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, cycles a non-empty queue may wait before a forced drain.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports pipe_valid/pipe_regwrite  input  1/1  pipeline writeback slot valid / requests register write.
REQ-007 SHALL have ports pipe_rd  input  5, pipe_result_src  input  2  destination and result select (0 ALU, 1 load, 2 PC+4, 3 immediate).
REQ-008 SHALL have ports pipe_alu_result, pipe_load_data, pipe_pc_plus4, pipe_imm  input  XLEN each  candidate results.
REQ-009 SHALL have ports pipe_funct3  input  3, pipe_addr_lo  input  2  load size/sign and byte offset.
REQ-010 SHALL have ports ll_valid input 1, ll_ready output 1, ll_rd input 5, ll_data input XLEN  long-latency unit result handshake.
REQ-011 SHALL have port pipe_stall  output  1  pipeline must hold its writeback slot this cycle.
REQ-012 SHALL have ports rf_we output 1, rf_rd output 5, rf_wdata output XLEN  registered register-file write port.

Function
REQ-013 SHALL select pipeline result by pipe_result_src; src=1 passes the load-aligned value of REQ-014.
REQ-014 SHALL align loads: funct3 000/100 byte at pipe_addr_lo sign/zero-extended; 001/101 halfword at pipe_addr_lo[1] sign/zero-extended; 010 and all others full word.
REQ-015 SHALL treat the pipeline slot as writing iff pipe_valid & pipe_regwrite & pipe_rd!=0 & !pipe_stall.
REQ-016 SHALL accept an ll transfer when ll_valid & ll_ready; ll_ready = queue not full (no same-cycle pop credit).
REQ-017 SHALL store accepted ll results in a LLQ_DEPTH FIFO with wrap-around read/write pointers and a count of 0..LLQ_DEPTH.
REQ-018 SHALL give the pipeline slot priority; queue head pops and writes only in cycles where the pipeline slot is not writing.
REQ-019 SHALL pop and discard a head entry with rd=0 without asserting rf_we.
REQ-020 SHALL count consecutive cycles queue non-empty without a pop; at count==STARVE_LIMIT assert pipe_stall for exactly one cycle, pop head in that cycle, clear counter.
REQ-021 SHALL clear the starvation counter on any pop or when queue empty.
REQ-022 SHALL register rf_we/rf_rd/rf_wdata: write selected in cycle N appears on port in cycle N+1 for one cycle; rf_we=0 in idle cycles.
REQ-023 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-024 SHALL combinationally drive pipe_stall from registered counter only (no input-to-stall path).

Reset
REQ-025 SHALL on rst_n low immediately clear rf_we, rf_rd, rf_wdata, pipe_stall, queue pointers, count and starvation counter; queued entries lost.
REQ-026 SHALL drive ll_ready=1 during and after reset; first write occurs no earlier than the first edge after rst_n rises.

Verification
REQ-027 ALU write: pipe_valid=1, regwrite=1, rd=5, src=0, alu=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x00001234.
REQ-028 Load align: src=1, load_data=0x80FF7F01, funct3=000, addr_lo=3 -> 0xFFFFFF80; funct3=101, addr_lo=2 -> 0x000080FF.
REQ-029 LL drain: ll push rd=7 data=0xAB while pipe_valid=0 -> written next idle cycle, rf_rd=7, rf_wdata=0xAB; rd=0 entry -> no write.
REQ-030 Full queue: 4 pushes with pipe writing every cycle -> ll_ready=0 after 4th, 5th push held until a pop.
REQ-031 Starvation: queue non-empty, pipe writing continuously -> pipe_stall=1 for one cycle after 8 cycles, head written, pipe result written the following cycle.
REQ-032 Reset mid-operation: rst_n low with 3 queued entries -> rf_we=0 immediately, count=0, ll_ready=1, no stale writes after release.
